// File: rtl/k_and_s_datapath_if.sv
// Memory-side bus of the K-and-S datapath: address, store data, read data and write enable
// for the 32x16 program/data RAM.
interface k_and_s_datapath_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_we;

   modport master (output ram_addr, output ram_wdata, output ram_we, input ram_rdata);
   modport slave  (input ram_addr, input ram_wdata, input ram_we, output ram_rdata);
endinterface

// File: rtl/k_and_s_datapath.sv
// K-and-S datapath: PC, IR, 4x16 register file, ALU and flags, steered by the control unit's
// strobes; returns the decoded instruction and registered ALU flags.
package k_and_s_pkg;
   typedef enum logic [3:0] {
      I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_LOAD, I_STORE, I_MOVE,
      I_ADD, I_SUB, I_AND, I_OR, I_HALT
   } decoded_instruction_type;

   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} alu_op_t;

   typedef struct packed {
      logic zero;
      logic neg;
      logic uov;
      logic sov;
   } flags_t;
endpackage

module k_and_s_datapath
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    branch,
   input  logic                    pc_enable,
   input  logic                    ir_enable,
   input  logic                    write_reg_enable,
   input  logic                    addr_sel,
   input  logic                    c_sel,
   input  logic [1:0]              operation,
   input  logic                    flags_reg_enable,
   input  logic                    ram_write_enable,
   output decoded_instruction_type decoded_instruction,
   output logic                    zero_op,
   output logic                    neg_op,
   output logic                    unsigned_overflow,
   output logic                    signed_overflow,
   k_and_s_datapath_if.master      mem
);
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];
   flags_t            flags_q, flags_d;

   logic [1:0]        a_idx, b_idx, dest_idx;
   logic [DATA_W-1:0] alu_a, alu_b, alu_res;
   logic [DATA_W:0]   sum_ext, diff_ext;
   flags_t            alu_flags;
   logic              unused_ir_bit;

   assign unused_ir_bit = ir_q[7];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      decoded_instruction = I_NOP;
      case (ir_q[15:8])
         8'h01: decoded_instruction = I_BRANCH;
         8'h02: decoded_instruction = I_BZERO;
         8'h03: decoded_instruction = I_BNEG;
         8'h81: decoded_instruction = I_LOAD;
         8'h82: decoded_instruction = I_STORE;
         8'h91: decoded_instruction = I_MOVE;
         8'hA1: decoded_instruction = I_ADD;
         8'hA2: decoded_instruction = I_SUB;
         8'hA3: decoded_instruction = I_AND;
         8'hA4: decoded_instruction = I_OR;
         8'hFF: decoded_instruction = I_HALT;
         default: decoded_instruction = I_NOP;
      endcase
   end

   // MOVE reads its source on both ports so OR yields a plain copy.
   always_comb begin
      a_idx    = ir_q[3:2];
      b_idx    = ir_q[1:0];
      dest_idx = ir_q[5:4];
      case (decoded_instruction)
         I_STORE: a_idx = ir_q[6:5];
         I_LOAD:  dest_idx = ir_q[6:5];
         I_MOVE: begin
            a_idx    = ir_q[1:0];
            dest_idx = ir_q[3:2];
         end
         default: ;
      endcase
   end

   assign alu_a    = regs_q[a_idx];
   assign alu_b    = regs_q[b_idx];
   assign sum_ext  = {1'b0, alu_a} + {1'b0, alu_b};
   assign diff_ext = {1'b0, alu_a} - {1'b0, alu_b};

   // The top bit of the zero-extended difference is set exactly when A < B (borrow).
   always_comb begin
      alu_res       = '0;
      alu_flags     = '0;
      case (alu_op_t'(operation))
         OP_ADD: begin
            alu_res       = sum_ext[DATA_W-1:0];
            alu_flags.uov = sum_ext[DATA_W];
            alu_flags.sov = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
         end
         OP_SUB: begin
            alu_res       = diff_ext[DATA_W-1:0];
            alu_flags.uov = diff_ext[DATA_W];
            alu_flags.sov = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
         end
         OP_AND: alu_res = alu_a & alu_b;
         OP_OR:  alu_res = alu_a | alu_b;
         default: ;
      endcase
      alu_flags.zero = (alu_res == '0);
      alu_flags.neg  = alu_res[DATA_W-1];
   end

   // The PC branch target is taken from the IR as it stands before any same-cycle IR load.
   always_comb begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      regs_d  = regs_q;
      flags_d = flags_q;
      if (pc_enable)
         pc_d = branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
      if (ir_enable)
         ir_d = mem.ram_rdata;
      if (write_reg_enable)
         regs_d[dest_idx] = c_sel ? mem.ram_rdata : alu_res;
      if (flags_reg_enable)
         flags_d = alu_flags;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         ir_q    <= '0;
         // NOTE: the register file is four flops wide, not a RAM, so it can and must clear on reset.
         regs_q  <= '{default: '0};
         flags_q <= '0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         regs_q  <= regs_d;
         flags_q <= flags_d;
      end
   end

   assign zero_op           = flags_q.zero;
   assign neg_op            = flags_q.neg;
   assign unsigned_overflow = flags_q.uov;
   assign signed_overflow   = flags_q.sov;

   assign mem.ram_addr  = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;
   assign mem.ram_wdata = alu_a;
   assign mem.ram_we    = ram_write_enable;
endmodule
